// File: rtl/rk4_stepper_pkg.sv
// rtl/rk4_stepper_pkg.sv - shared constants, state encoding and Q-format saturation helpers
// for the RK4 stepper.
package rk_pkg;

  localparam int FRAC = 8;
  localparam logic signed [15:0] ONE_SIXTH = 16'sh2AAB;

  typedef enum logic [2:0] {
    IDLE,
    K1,
    K2,
    K3,
    K4,
    UPD1,
    UPD2,
    FIN
  } rk_state_t;

  function automatic logic [15:0] sat16(input logic signed [39:0] v);
    logic [15:0] r;
    if (v > 40'sd32767) r = 16'h7FFF;
    else if (v < -40'sd32768) r = 16'h8000;
    else r = v[15:0];
    return r;
  endfunction

  function automatic logic ovf16(input logic signed [39:0] v);
    return (v > 40'sd32767) || (v < -40'sd32768);
  endfunction

  // Q16.16 slope down to Q8.8; the arithmetic shift floors toward -inf.
  function automatic logic signed [39:0] q16_to_q8_wide(input logic signed [31:0] d);
    return 40'(d) >>> 8;
  endfunction

  function automatic logic [15:0] q16_to_q8(input logic signed [31:0] d);
    return sat16(q16_to_q8_wide(d));
  endfunction

  function automatic logic q16_to_q8_ovf(input logic signed [31:0] d);
    return ovf16(q16_to_q8_wide(d));
  endfunction

endpackage

// File: rtl/rk4_stepper_fx_mul_sat.sv
// rtl/rk4_stepper_fx_mul_sat.sv - combinational signed Q8.8 multiply, floor shift and
// 16-bit saturation with an overflow flag.
module fx_mul_sat
  import rk_pkg::*;
#(
  parameter int FRAC = rk_pkg::FRAC
) (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic [15:0]        p,
  output logic               ovf
);

  logic signed [31:0] prod;
  logic signed [39:0] shifted;

  always_comb begin
    prod    = a * b;
    shifted = 40'(prod) >>> FRAC;
    p       = sat16(shifted);
    ovf     = ovf16(shifted);
  end

endmodule

// File: rtl/rk4_stepper.sv
// rtl/rk4_stepper.sv - RK4 sequencer: issues four slope evaluations per step to the function
// stage, then integrates y += h/6*(k1+2k2+2k3+k4) and x += h.
module rk4_stepper
  import rk_pkg::*;
#(
  parameter int FRAC  = rk_pkg::FRAC,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      x0,
  input  logic [15:0]      y0,
  input  logic [15:0]      h,
  input  logic [CNT_W-1:0] n_steps,
  output logic             busy,
  output logic             f_req,
  output logic [15:0]      f_x,
  output logic [15:0]      f_y,
  input  logic [31:0]      f_dydx,
  input  logic             f_valid,
  output logic [15:0]      x_out,
  output logic [15:0]      y_out,
  output logic             out_valid,
  output logic             done,
  output logic             sat
);

  rk_state_t state, state_nxt;

  logic signed [15:0] x_r, y_r, h_r;
  logic signed [15:0] k1_r, k2_r, k3_r, k4_r, p_r;
  logic [CNT_W-1:0]   n_r, cnt_r;

  logic signed [15:0] h_half, kin, mul_a, mul_b, mul_p, s_q;
  logic               kin_ovf, mul_ovf, s_ovf, last_step;
  logic signed [18:0] s_w;
  logic signed [31:0] sixth_w;
  logic signed [39:0] x_half_w, x_full_w, y_mul_w, y_upd_w;

  // One multiplier, time-shared: h/2*k or h*k in the K states, h*S in UPD1.
  fx_mul_sat #(.FRAC(FRAC)) u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  always_comb begin
    h_half  = h_r >>> 1;
    kin     = q16_to_q8(f_dydx);
    kin_ovf = q16_to_q8_ovf(f_dydx);

    mul_a = h_r;
    mul_b = kin;
    case (state)
      K1, K2: mul_a = h_half;
      UPD1:   mul_b = s_q;
      default: ;
    endcase

    s_w   = 19'(k1_r) + (19'(k2_r) <<< 1) + (19'(k3_r) <<< 1) + 19'(k4_r);
    s_q   = sat16(40'(s_w));
    s_ovf = ovf16(40'(s_w));

    sixth_w  = p_r * ONE_SIXTH;
    x_half_w = 40'(x_r) + 40'(h_half);
    x_full_w = 40'(x_r) + 40'(h_r);
    y_mul_w  = 40'(y_r) + 40'(mul_p);
    y_upd_w  = 40'(y_r) + 40'(sixth_w >>> 16);

    last_step = ({1'b0, cnt_r} + 1'b1) >= {1'b0, n_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    f_req     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = (n_steps == '0) ? FIN : K1;
      K1: begin
        f_req = 1'b1;
        if (f_valid) state_nxt = K2;
      end
      K2: begin
        f_req = 1'b1;
        if (f_valid) state_nxt = K3;
      end
      K3: begin
        f_req = 1'b1;
        if (f_valid) state_nxt = K4;
      end
      K4: begin
        f_req = 1'b1;
        if (f_valid) state_nxt = UPD1;
      end
      UPD1:    state_nxt = UPD2;
      UPD2:    state_nxt = last_step ? FIN : K1;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r       <= '0;
      y_r       <= '0;
      h_r       <= '0;
      n_r       <= '0;
      cnt_r     <= '0;
      k1_r      <= '0;
      k2_r      <= '0;
      k3_r      <= '0;
      k4_r      <= '0;
      p_r       <= '0;
      f_x       <= '0;
      f_y       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      sat       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            x_r   <= x0;
            y_r   <= y0;
            h_r   <= h;
            n_r   <= n_steps;
            cnt_r <= '0;
            sat   <= 1'b0;
            f_x   <= x0;
            f_y   <= y0;
          end
        end
        K1, K2: begin
          if (f_valid) begin
            if (state == K1) k1_r <= kin;
            else             k2_r <= kin;
            f_x <= sat16(x_half_w);
            f_y <= sat16(y_mul_w);
            sat <= sat | kin_ovf | mul_ovf | ovf16(x_half_w) | ovf16(y_mul_w);
          end
        end
        K3: begin
          if (f_valid) begin
            k3_r <= kin;
            f_x  <= sat16(x_full_w);
            f_y  <= sat16(y_mul_w);
            sat  <= sat | kin_ovf | mul_ovf | ovf16(x_full_w) | ovf16(y_mul_w);
          end
        end
        K4: begin
          if (f_valid) begin
            k4_r <= kin;
            sat  <= sat | kin_ovf;
          end
        end
        UPD1: begin
          p_r <= mul_p;
          sat <= sat | s_ovf | mul_ovf;
        end
        UPD2: begin
          // The new state doubles as the next step's K1 operands.
          x_r       <= sat16(x_full_w);
          y_r       <= sat16(y_upd_w);
          f_x       <= sat16(x_full_w);
          f_y       <= sat16(y_upd_w);
          x_out     <= sat16(x_full_w);
          y_out     <= sat16(y_upd_w);
          out_valid <= 1'b1;
          cnt_r     <= cnt_r + 1'b1;
          sat       <= sat | ovf16(x_full_w) | ovf16(y_upd_w);
        end
        FIN:     done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rk4_stepper.sv
// tb/tb_rk4_stepper.sv - self-checking bench for rk4_stepper with an integer-arithmetic
// RK4 reference model and a latency-configurable function evaluator.
module tb_rk4_stepper;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] x0, y0, h, n_steps;
  logic        busy, f_req, f_valid, out_valid, done, sat;
  logic [15:0] f_x, f_y, x_out, y_out;
  logic [31:0] f_dydx;

  int checks = 0;
  int failures = 0;

  int mode = 0;
  int ca = 0;
  int cb = 0;
  int lat = 0;
  bit noise = 1'b0;
  bit noise_bit = 1'b0;
  int wcnt = 0;

  always #5 clk = ~clk;

  rk4_stepper dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .h(h), .n_steps(n_steps),
    .busy(busy), .f_req(f_req), .f_x(f_x), .f_y(f_y), .f_dydx(f_dydx), .f_valid(f_valid),
    .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .done(done), .sat(sat)
  );

  // Evaluator: 0 = constant 1.0, 1 = f(x,y) = y, 2 = f = ca*y + cb*x (Q8.8 coefficients).
  function automatic int eval_f(int md, int a, int b, int x, int y);
    int r;
    case (md)
      0:       r = 65536;
      1:       r = y * 256;
      default: r = y * a + x * b;
    endcase
    return r;
  endfunction

  always_comb begin
    f_dydx  = 32'(eval_f(mode, ca, cb, int'($signed(f_x)), int'($signed(f_y))));
    f_valid = f_req ? (wcnt == lat) : noise_bit;
  end

  always @(posedge clk) begin
    if (!f_req || f_valid) wcnt <= 0;
    else                   wcnt <= wcnt + 1;
    noise_bit <= noise && ($urandom_range(1) == 1);
  end

  // Reference model
  bit m_sat;
  logic [15:0] exp_x[$], exp_y[$], exp_fx[$], exp_fy[$];

  function automatic int clamp(int v);
    if (v > 32767) begin m_sat = 1'b1; return 32767; end
    if (v < -32768) begin m_sat = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic int mulq(int a, int b);
    return clamp((a * b) >>> 8);
  endfunction

  function automatic int slope(int x, int y);
    return clamp(eval_f(mode, ca, cb, x, y) >>> 8);
  endfunction

  task automatic model_run(input logic [15:0] x0_i, y0_i, h_i, input int n_i);
    int x, y, hh, h2, xh, xf, yy, k1, k2, k3, k4, s, p;
    exp_x.delete(); exp_y.delete(); exp_fx.delete(); exp_fy.delete();
    m_sat = 1'b0;
    x = int'($signed(x0_i));
    y = int'($signed(y0_i));
    hh = int'($signed(h_i));
    h2 = hh >>> 1;
    for (int i = 0; i < n_i; i++) begin
      exp_fx.push_back(16'(x)); exp_fy.push_back(16'(y));
      k1 = slope(x, y);
      xh = clamp(x + h2);
      yy = clamp(y + mulq(h2, k1));
      exp_fx.push_back(16'(xh)); exp_fy.push_back(16'(yy));
      k2 = slope(xh, yy);
      yy = clamp(y + mulq(h2, k2));
      exp_fx.push_back(16'(xh)); exp_fy.push_back(16'(yy));
      k3 = slope(xh, yy);
      xf = clamp(x + hh);
      yy = clamp(y + mulq(hh, k3));
      exp_fx.push_back(16'(xf)); exp_fy.push_back(16'(yy));
      k4 = slope(xf, yy);
      s = clamp(k1 + 2 * k2 + 2 * k3 + k4);
      p = mulq(hh, s);
      y = clamp(y + ((p * 10923) >>> 16));
      x = clamp(x + hh);
      exp_x.push_back(16'(x)); exp_y.push_back(16'(y));
    end
  endtask

  // Observation of one run (cycle 0 = first cycle after the start edge)
  logic [15:0] obs_x[$], obs_y[$], obs_fx[$], obs_fy[$];
  int obs_c[$];
  int done_c, freq_n, acc_n, stab_err;
  bit busy0, sat0, sat_end, busy_done;

  task automatic run(input logic [15:0] x0_i, y0_i, h_i, input int n_i, input bit junk_start);
    logic [15:0] px, py;
    bit hold;
    obs_x.delete(); obs_y.delete(); obs_fx.delete(); obs_fy.delete(); obs_c.delete();
    done_c = -1; freq_n = 0; acc_n = 0; stab_err = 0; hold = 1'b0; px = '0; py = '0;
    @(negedge clk);
    x0 = x0_i; y0 = y0_i; h = h_i; n_steps = 16'(n_i); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clk);
      if (junk_start && c == 2) begin
        start = 1'b1; x0 = 16'h1234; y0 = 16'h4321; h = 16'h0200; n_steps = 16'd9;
      end
      if (junk_start && c == 3) start = 1'b0;
      if (c == 0) begin busy0 = busy; sat0 = sat; end
      if (f_req) freq_n++;
      if (f_req && hold && (f_x !== px || f_y !== py)) stab_err++;
      hold = f_req && !f_valid; px = f_x; py = f_y;
      if (f_req && f_valid) begin acc_n++; obs_fx.push_back(f_x); obs_fy.push_back(f_y); end
      if (out_valid) begin obs_x.push_back(x_out); obs_y.push_back(y_out); obs_c.push_back(c); end
      if (done) begin done_c = c; sat_end = sat; busy_done = busy; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; h = '0; n_steps = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({f_req, busy, out_valid, done, sat} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b want=00000", {f_req, busy, out_valid, done, sat});
    end
    checks++;
    if ({f_x, f_y, x_out, y_out} !== 64'h0) begin
      failures++; $display("FAIL reset_data got=%h want=0", {f_x, f_y, x_out, y_out});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b want=0", busy); end
  endtask

  task automatic test_const_slope;
    mode = 0; lat = 0;
    run(16'h0000, 16'h0000, 16'h0100, 1, 1'b0);
    checks++;
    if (obs_c.size() !== 1 || obs_c[0] !== 6) begin
      failures++; $display("FAIL const_ov_cycle n=%0d c=%0d want 1 at 6", obs_c.size(), obs_c.size() ? obs_c[0] : -1);
    end
    checks++;
    if (x_out !== 16'h0100 || y_out !== 16'h0100) begin
      failures++; $display("FAIL const_xy got=%h/%h want=0100/0100", x_out, y_out);
    end
    checks++;
    if (done_c !== 7 || busy_done !== 1'b0) begin
      failures++; $display("FAIL const_done cycle=%0d busy=%b want 7/0", done_c, busy_done);
    end
    checks++;
    if (sat_end !== 1'b0 || busy0 !== 1'b1 || acc_n !== 4) begin
      failures++; $display("FAIL const_misc sat=%b busy0=%b acc=%0d want 0/1/4", sat_end, busy0, acc_n);
    end
  endtask

  task automatic test_f_eq_y(input int l);
    logic [15:0] seq_y[4];
    logic [15:0] seq_x[4];
    int per;
    seq_y = '{16'h0100, 16'h0140, 16'h0150, 16'h01A8};
    seq_x = '{16'h0000, 16'h0040, 16'h0040, 16'h0080};
    mode = 1; lat = l; per = 4 * (l + 1) + 2;
    run(16'h0000, 16'h0100, 16'h0080, 1, 1'b0);
    checks++;
    if (obs_fy.size() !== 4) begin
      failures++; $display("FAIL fy_count_L%0d got=%0d want=4", l, obs_fy.size());
    end
    for (int i = 0; i < 4 && i < obs_fy.size(); i++) begin
      checks++;
      if (obs_fy[i] !== seq_y[i] || obs_fx[i] !== seq_x[i]) begin
        failures++; $display("FAIL fy_op%0d_L%0d got=%h/%h want=%h/%h", i, l, obs_fx[i], obs_fy[i], seq_x[i], seq_y[i]);
      end
    end
    checks++;
    if (x_out !== 16'h0080 || y_out !== 16'h01A6) begin
      failures++; $display("FAIL fy_xy_L%0d got=%h/%h want=0080/01A6", l, x_out, y_out);
    end
    checks++;
    if (obs_c.size() !== 1 || obs_c[0] !== per || done_c !== per + 1) begin
      failures++; $display("FAIL fy_timing_L%0d ov=%0d done=%0d want %0d/%0d", l, obs_c.size() ? obs_c[0] : -1, done_c, per, per + 1);
    end
    checks++;
    if (stab_err !== 0 || freq_n !== 4 * (l + 1)) begin
      failures++; $display("FAIL fy_hold_L%0d unstable=%0d req_cycles=%0d want 0/%0d", l, stab_err, freq_n, 4 * (l + 1));
    end
  endtask

  task automatic test_saturation;
    mode = 0; lat = 0;
    run(16'h0000, 16'h7F00, 16'h0100, 2, 1'b0);
    checks++;
    if (obs_y.size() !== 2 || obs_y[0] !== 16'h7FFF || obs_y[1] !== 16'h7FFF) begin
      failures++; $display("FAIL sat_y got=%h want=7FFF", obs_y.size() ? obs_y[0] : 16'hxxxx);
    end
    checks++;
    if (sat_end !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b want=1", sat_end); end
    repeat (3) @(negedge clk);
    checks++;
    if (sat !== 1'b1) begin failures++; $display("FAIL sat_sticky got=%b want=1", sat); end
    run(16'h0000, 16'h0000, 16'h0100, 1, 1'b0);
    checks++;
    if (sat0 !== 1'b0 || sat_end !== 1'b0) begin
      failures++; $display("FAIL sat_clear got=%b/%b want=0/0", sat0, sat_end);
    end
  endtask

  task automatic test_zero_steps;
    logic [15:0] px, py;
    px = x_out; py = y_out;
    run(16'h0505, 16'h0606, 16'h0707, 0, 1'b0);
    checks++;
    if (freq_n !== 0 || busy0 !== 1'b1 || done_c !== 1) begin
      failures++; $display("FAIL zero_steps req=%0d busy0=%b done=%0d want 0/1/1", freq_n, busy0, done_c);
    end
    checks++;
    if (x_out !== px || y_out !== py || obs_c.size() !== 0) begin
      failures++; $display("FAIL zero_hold got=%h/%h want=%h/%h", x_out, y_out, px, py);
    end
  endtask

  task automatic test_reset_mid;
    int evts;
    mode = 0; lat = 0; evts = 0;
    @(negedge clk);
    x0 = 16'h0000; y0 = 16'h0000; h = 16'h0100; n_steps = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (f_req !== 1'b1 || x_out !== 16'h0100) begin
      failures++; $display("FAIL mid_pre req=%b x=%h want 1/0100", f_req, x_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({f_req, busy, out_valid, done, sat, f_x, f_y, x_out, y_out} !== 69'h0) begin
      failures++; $display("FAIL mid_reset got=%h want=0", {f_req, busy, out_valid, done, sat, f_x, f_y, x_out, y_out});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) evts++;
    end
    checks++;
    if (evts !== 0) begin failures++; $display("FAIL mid_quiet events=%0d want=0", evts); end
    run(16'h0100, 16'h0080, 16'h0040, 2, 1'b0);
    model_run(16'h0100, 16'h0080, 16'h0040, 2);
    checks++;
    if (obs_y.size() !== 2 || obs_x[1] !== exp_x[1] || obs_y[1] !== exp_y[1]) begin
      failures++; $display("FAIL mid_fresh got=%h/%h want=%h/%h", x_out, y_out, exp_x[1], exp_y[1]);
    end
  endtask

  task automatic test_random(input int iters, input bit b2b);
    logic [15:0] rx, ry, rh;
    int rn, per;
    for (int it = 0; it < iters; it++) begin
      mode = 2; noise = 1'b1;
      ca = int'($urandom_range(768)) - 384;
      cb = int'($urandom_range(768)) - 384;
      lat = int'($urandom_range(2));
      rn = int'($urandom_range(3, 1));
      rx = 16'(int'($urandom_range(8191)) - 4096);
      ry = ($urandom_range(3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(8191)) - 4096);
      rh = 16'(int'($urandom_range(383)) - 128);
      per = 4 * (lat + 1) + 2;
      run(rx, ry, rh, rn, b2b);
      model_run(rx, ry, rh, rn);
      checks++;
      if (obs_fy.size() !== exp_fy.size() || obs_y.size() !== rn) begin
        failures++; $display("FAIL rnd%0d_counts ops=%0d steps=%0d want %0d/%0d", it, obs_fy.size(), obs_y.size(), exp_fy.size(), rn);
      end
      for (int i = 0; i < exp_fy.size() && i < obs_fy.size(); i++) begin
        checks++;
        if (obs_fx[i] !== exp_fx[i] || obs_fy[i] !== exp_fy[i]) begin
          failures++; $display("FAIL rnd%0d_op%0d got=%h/%h want=%h/%h", it, i, obs_fx[i], obs_fy[i], exp_fx[i], exp_fy[i]);
        end
      end
      for (int i = 0; i < rn && i < obs_y.size(); i++) begin
        checks++;
        if (obs_x[i] !== exp_x[i] || obs_y[i] !== exp_y[i] || obs_c[i] !== (i + 1) * per) begin
          failures++; $display("FAIL rnd%0d_step%0d got=%h/%h@%0d want=%h/%h@%0d", it, i, obs_x[i], obs_y[i], obs_c[i], exp_x[i], exp_y[i], (i + 1) * per);
        end
      end
      checks++;
      if (done_c !== rn * per + 1 || sat_end !== m_sat || stab_err !== 0) begin
        failures++; $display("FAIL rnd%0d_end done=%0d sat=%b unstable=%0d want %0d/%b/0", it, done_c, sat_end, stab_err, rn * per + 1, m_sat);
      end
    end
    noise = 1'b0;
  endtask

  initial begin
    test_reset();
    test_const_slope();
    test_f_eq_y(0);
    test_f_eq_y(3);
    test_saturation();
    test_zero_steps();
    test_reset_mid();
    test_random(6, 1'b0);
    test_random(3, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
